decodificador_botao: RTL and testbench
======================================

# decodificador_botao

Classifies debounced button activity into discrete user gestures (single click, double click, long press) and hands each gesture to the game control FSM via a one-entry valid/ack event slot. It sits directly downstream of the per-button debouncer, consuming its one-cycle press pulse and held level. It is the consumer end of the button pulse interface, so menu and action logic never times button activity itself.

## Interface
- LONG_CYCLES, 1000: clocks the button must stay held after the press pulse to count as a long press; legal range is 2 to 2^CNT_W−1.
- DOUBLE_CYCLES, 300: clocks after a release in which a second press makes a double click; legal range is 2 to 2^CNT_W−1.
- CNT_W, 16: width of the shared interval counter.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- press_pulse  in  1  one-cycle pulse from the debouncer on each stable press.
- held  in  1  debounced level; 1 while the button is pressed.
- ev_valid  out  1  event slot occupied.
- ev_code  out  2  event type: 1 = CLICK, 2 = DOUBLE, 3 = LONG; 0 when the slot is empty.
- ev_ack  in  1  consumer takes the event; only meaningful while ev_valid = 1.
- ev_lost  out  1  sticky flag; an event was dropped because the slot was full.

## Operation
- FSM states are IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED and LONG_HELD. The counter `cnt` (CNT_W bits) saturates at all ones.
- **IDLE:** press_pulse → PRESSED, cnt = 0.
- **PRESSED:**
  - held = 1: cnt increments.
  - held = 1 and cnt == LONG_CYCLES−1: emit LONG → LONG_HELD.
  - held = 0: → WAIT_SECOND with cnt = 0.
- **WAIT_SECOND:**
  - press_pulse → SECOND_PRESSED.
  - Otherwise cnt increments; when cnt == DOUBLE_CYCLES−1, emit CLICK → IDLE.
  - If press_pulse arrives on the same cycle as the timeout, press_pulse wins.
- **SECOND_PRESSED:** held = 0 → emit DOUBLE → IDLE. The duration of the second press is not measured.
- **LONG_HELD:** held = 0 → IDLE. There is no auto-repeat.
- press_pulse is ignored in PRESSED, SECOND_PRESSED and LONG_HELD.
- **Event slot:**
  - An emitted event loads the slot when it is empty, or when ev_valid & ev_ack in the same cycle (back-to-back; ev_valid stays 1).
  - If the slot is full and not acked, the new event is dropped and ev_lost is set. The slot keeps the older event.
  - ev_valid & ev_ack with no new event empties the slot: ev_valid = 0, ev_code = 0.
  - ev_lost clears only on reset.
- **Reset (asynchronous, any time, including mid-gesture):** FSM → IDLE, cnt = 0, ev_valid = 0, ev_code = 0, ev_lost = 0. An in-progress gesture is discarded.

## Timing
- Count edges with the press_pulse edge as E0.
- **LONG:** with held = 1 throughout, ev_valid/ev_code = 3 are visible after edge E(LONG_CYCLES).
- **CLICK:** let the release be the first edge ER sampling held = 0. ev_valid is visible after edge ER+DOUBLE_CYCLES, provided there is no press_pulse at ER+1 through ER+DOUBLE_CYCLES.
- **DOUBLE:** ev_valid is visible after the first edge sampling held = 0 in SECOND_PRESSED.
- **Acknowledge:** the slot clears on the edge that samples ev_ack = 1 with ev_valid = 1. The consumer may hold ev_ack high continuously.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- DECODIFICADOR_BOTAO_DOUBLE_EN:
  - **Defined:** behaviour as above.
  - **Undefined:** WAIT_SECOND and SECOND_PRESSED are not built, and DOUBLE_CYCLES is ignored. Release in PRESSED emits CLICK → IDLE, with ev_valid visible after the release edge. Code 2 is never produced.

## Structure
- Shared package `decodificador_botao_pkg` holds:
  - the FSM state encoding;
  - the event code constants EV_NONE = 0, EV_CLICK = 1, EV_DOUBLE = 2, EV_LONG = 3.
- Sub-module `decodificador_botao_slot` is the one-entry valid/ack event register plus the ev_lost logic. Its inputs are load and code; its outputs are ev_valid, ev_code and ev_lost.
- The FSM and counter stay in the top module.

## Test plan
Bench parameters: LONG_CYCLES = 8, DOUBLE_CYCLES = 5, macro defined, ev_ack tied high unless noted.
- **Click:** press_pulse at E0, held high for E1–E3, low from E4 → ev_code = 1 visible after E9, then cleared after E10.
- **Double click:** press_pulse at E0, release at E3, press_pulse at E5, release at E7 → ev_code = 2 visible after E7, with no CLICK.
- **Long press:** press_pulse at E0, held high through E20 → single ev_code = 3 visible after E8, no further events, IDLE on release.
- **Slot full:** ev_ack = 0; click, then long → slot keeps code 1, ev_lost = 1; ack → slot empties, ev_lost stays 1.
- **Reset mid-gesture:** press_pulse at E0, rst_n low mid-cycle 4 → outputs 0 immediately; after release of reset, held low → no event.
- **Macro undefined:** press_pulse at E0, release at E4 → ev_code = 1 visible after E4.

Source files
------------

// File: rtl/decodificador_botao_pkg.sv
// Shared types for the button gesture decoder: FSM state encoding and event codes.
package decodificador_botao_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_WAIT_SECOND    = 3'd2,
    ST_SECOND_PRESSED = 3'd3,
    ST_LONG_HELD      = 3'd4
  } state_t;

  typedef logic [1:0] ev_code_t;

  localparam ev_code_t EV_NONE   = 2'd0;
  localparam ev_code_t EV_CLICK  = 2'd1;
  localparam ev_code_t EV_DOUBLE = 2'd2;
  localparam ev_code_t EV_LONG   = 2'd3;

endpackage

// File: rtl/decodificador_botao_slot.sv
// One-entry valid/ack event register with a sticky flag for events dropped while full.
module decodificador_botao_slot
  import decodificador_botao_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  ev_code_t code,
  input  logic     ev_ack,
  output logic     ev_valid,
  output ev_code_t ev_code,
  output logic     ev_lost
);

  logic can_accept;

  // An ack in the same cycle frees the slot, so a new event can replace the old one back-to-back.
  assign can_accept = !ev_valid || ev_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_code  <= EV_NONE;
      ev_lost  <= 1'b0;
    end else if (load && can_accept) begin
      ev_valid <= 1'b1;
      ev_code  <= code;
    end else if (load) begin
      ev_lost  <= 1'b1;
    end else if (ev_valid && ev_ack) begin
      ev_valid <= 1'b0;
      ev_code  <= EV_NONE;
    end
  end

endmodule

// File: rtl/decodificador_botao.sv
// Classifies debounced button activity into CLICK / DOUBLE / LONG events.
// Double-click detection is built only when DECODIFICADOR_BOTAO_DOUBLE_EN is defined.
module decodificador_botao
  import decodificador_botao_pkg::*;
#(
  parameter int LONG_CYCLES   = 1000,
  parameter int DOUBLE_CYCLES = 300,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press_pulse,
  input  logic       held,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ack,
  output logic       ev_lost
);

  if (LONG_CYCLES < 2 || LONG_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_long
    $error("decodificador_botao: LONG_CYCLES out of range");
  end
  if (DOUBLE_CYCLES < 2 || DOUBLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_double
    $error("decodificador_botao: DOUBLE_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef DECODIFICADOR_BOTAO_DOUBLE_EN
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 1);
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             emit;
  ev_code_t         emit_code;

  // Interval counter saturates so an over-long hold can never wrap into a false match.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    emit      = 1'b0;
    emit_code = EV_NONE;
    unique case (state)
      ST_IDLE: begin
        if (press_pulse) begin
          state_n = ST_PRESSED;
          cnt_n   = '0;
        end
      end
      ST_PRESSED: begin
        if (held) begin
          cnt_n = cnt_inc;
          if (cnt == LONG_LAST) begin
            emit      = 1'b1;
            emit_code = EV_LONG;
            state_n   = ST_LONG_HELD;
          end
        end else begin
`ifdef DECODIFICADOR_BOTAO_DOUBLE_EN
          state_n = ST_WAIT_SECOND;
          cnt_n   = '0;
`else
          emit      = 1'b1;
          emit_code = EV_CLICK;
          state_n   = ST_IDLE;
          cnt_n     = '0;
`endif
        end
      end
`ifdef DECODIFICADOR_BOTAO_DOUBLE_EN
      // A press on the timeout cycle still counts as the second click.
      ST_WAIT_SECOND: begin
        if (press_pulse) begin
          state_n = ST_SECOND_PRESSED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt == DOUBLE_LAST) begin
            emit      = 1'b1;
            emit_code = EV_CLICK;
            state_n   = ST_IDLE;
            cnt_n     = '0;
          end
        end
      end
      ST_SECOND_PRESSED: begin
        if (!held) begin
          emit      = 1'b1;
          emit_code = EV_DOUBLE;
          state_n   = ST_IDLE;
        end
      end
`endif
      ST_LONG_HELD: begin
        if (!held) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  decodificador_botao_slot u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (emit),
    .code     (emit_code),
    .ev_ack   (ev_ack),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_lost  (ev_lost)
  );

endmodule

// File: tb/tb_decodificador_botao.sv
// Directed bench for decodificador_botao with an event scoreboard; adapts to DECODIFICADOR_BOTAO_DOUBLE_EN.
module tb_decodificador_botao;
  import decodificador_botao_pkg::*;

  localparam int LONG_CYC   = 8;
  localparam int DOUBLE_CYC = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       press_pulse = 1'b0;
  logic       held = 1'b0;
  logic       ev_ack = 1'b1;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_lost;

  int total = 0;
  int bad = 0;
  logic [1:0] sb[$];
  logic [1:0] exp_code;

  decodificador_botao #(
    .LONG_CYCLES   (LONG_CYC),
    .DOUBLE_CYCLES (DOUBLE_CYC),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_pulse (press_pulse),
    .held        (held),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_ack      (ev_ack),
    .ev_lost     (ev_lost)
  );

  always #5 clk = ~clk;

  // Each accepted event is consumed from the scoreboard when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ack) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("[TB] FAIL unexpected_event: got code=%0d, required no event", ev_code);
      end
      if (sb.size() != 0) begin
        exp_code = sb.pop_front();
        total++;
        assert (ev_code === exp_code) else begin
          bad++;
          $error("[TB] FAIL event_code: got %0d, required %0d", ev_code, exp_code);
        end
      end
    end
  end

  task automatic applyStimulus(input logic pp, input logic h);
    press_pulse = pp;
    held        = h;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [1:0] c, input logic l);
    total++;
    assert ({ev_valid, ev_code, ev_lost} === {v, c, l}) else begin
      bad++;
      $error("[TB] FAIL %s: got valid=%0b code=%0d lost=%0b, required valid=%0b code=%0d lost=%0b",
             tag, ev_valid, ev_code, ev_lost, v, c, l);
    end
  endtask

  initial begin
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("reset", 1'b0, EV_NONE, 1'b0);
    rst_n = 1'b1;
    applyStimulus(0, 0);

    // Single click
    sb.push_back(EV_CLICK);
    applyStimulus(1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);
`ifdef DECODIFICADOR_BOTAO_DOUBLE_EN
    applyStimulus(0, 0);
    for (int i = 0; i < DOUBLE_CYC - 1; i++) applyStimulus(0, 0);
    checkOutput("click_pre", 1'b0, EV_NONE, 1'b0);
    applyStimulus(0, 0);
`else
    checkOutput("click_pre", 1'b0, EV_NONE, 1'b0);
    applyStimulus(0, 0);
`endif
    checkOutput("click", 1'b1, EV_CLICK, 1'b0);
    applyStimulus(0, 0);
    checkOutput("click_clear", 1'b0, EV_NONE, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0);

`ifdef DECODIFICADOR_BOTAO_DOUBLE_EN
    // Double click
    sb.push_back(EV_DOUBLE);
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    checkOutput("double_pre", 1'b0, EV_NONE, 1'b0);
    applyStimulus(0, 0);
    checkOutput("double", 1'b1, EV_DOUBLE, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0);
    checkOutput("double_no_click", 1'b0, EV_NONE, 1'b0);
`else
    // Two quick presses without double detection give two clicks
    sb.push_back(EV_CLICK);
    sb.push_back(EV_CLICK);
    applyStimulus(1, 1);
    applyStimulus(0, 0);
    checkOutput("click_a", 1'b1, EV_CLICK, 1'b0);
    applyStimulus(1, 1);
    applyStimulus(0, 0);
    checkOutput("click_b", 1'b1, EV_CLICK, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0);
`endif

    // Long press
    sb.push_back(EV_LONG);
    applyStimulus(1, 1);
    for (int i = 0; i < LONG_CYC - 1; i++) applyStimulus(0, 1);
    checkOutput("long_pre", 1'b0, EV_NONE, 1'b0);
    applyStimulus(0, 1);
    checkOutput("long", 1'b1, EV_LONG, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1);
    checkOutput("long_no_repeat", 1'b0, EV_NONE, 1'b0);
    applyStimulus(0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0);
    checkOutput("long_release", 1'b0, EV_NONE, 1'b0);

    // Slot full: click held unacked, long press dropped
    ev_ack = 1'b0;
    sb.push_back(EV_CLICK);
    applyStimulus(1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);
    applyStimulus(0, 0);
`ifdef DECODIFICADOR_BOTAO_DOUBLE_EN
    for (int i = 0; i < DOUBLE_CYC; i++) applyStimulus(0, 0);
`endif
    checkOutput("full_click", 1'b1, EV_CLICK, 1'b0);
    applyStimulus(1, 1);
    for (int i = 0; i < LONG_CYC; i++) applyStimulus(0, 1);
    checkOutput("full_keep", 1'b1, EV_CLICK, 1'b1);
    ev_ack = 1'b1;
    applyStimulus(0, 1);
    checkOutput("full_ack", 1'b0, EV_NONE, 1'b1);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("lost_sticky", 1'b0, EV_NONE, 1'b1);

    // Reset in the middle of a gesture
    applyStimulus(1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 1'b0, EV_NONE, 1'b0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(0, 0);
    checkOutput("reset_discard", 1'b0, EV_NONE, 1'b0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("[TB] FAIL missing_events: got %0d pending, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
